// File: rtl/ram_sp_sync_be_if.sv
// Request/response bundle for the single-port byte-enable RAM.
// The master issues requests; the slave returns read data and status.
interface ram_sp_sync_be_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                cs;
    logic                we;
    logic                re;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                ready;
    logic                err;

    modport master (
        output cs, we, re, addr, wdata, be,
        input  rdata, rvalid, ready, err
    );

    modport slave (
        input  cs, we, re, addr, wdata, be,
        output rdata, rvalid, ready, err
    );
endinterface

// File: rtl/ram_sp_sync_be.sv
// Single-port synchronous RAM with byte enables, pipelined reads,
// selectable read-during-write result and a zeroing sweep after reset.
module ram_sp_sync_be #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 1024,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic              clk,
    input logic              rst_n,
    ram_sp_sync_be_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  clr_cnt;
    logic [IDX_W-1:0]  clr_cnt_nxt;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc;
    logic              in_range;
    logic              do_wr;
    logic              do_rd;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;
    logic [DATA_W-1:0] rd_word;

    logic [RD_LAT-1:0] pv;
    logic [DATA_W-1:0] pd [RD_LAT];
    logic              err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + IDX_W'(1);
                if (clr_cnt == LAST) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end
            end
            IDLE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ready = (state == IDLE);

    // Requests are only honoured outside reset and once the sweep is done.
    assign acc      = bus.cs & (state == IDLE) & rst_n;
    assign in_range = ({1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH));
    assign idx      = bus.addr[IDX_W-1:0];
    assign do_wr    = acc & bus.we & in_range;
    assign do_rd    = acc & bus.re;

    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[idx];
        end
        new_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (bus.we && bus.be[i]) begin
                new_word[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
        rd_word = '0;
        if (in_range) begin
            rd_word = (RDW_MODE != 0) ? new_word : old_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (do_wr) begin
            mem[idx] <= new_word;
        end
    end

    // Data stages only move with a valid beat, so the last one holds rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv    <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= do_rd;
            if (do_rd) begin
                pd[0] <= rd_word;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
            err_q <= acc & (bus.we | bus.re) & ~in_range;
        end
    end

    assign bus.rdata  = pd[RD_LAT-1];
    assign bus.rvalid = pv[RD_LAT-1];
    assign bus.err    = err_q;
endmodule

// File: tb/tb_ram_sp_sync_be.sv
// Bench for ram_sp_sync_be: three configurations share one stimulus
// stream and are checked every cycle against a word-level memory model.
module tb_ram_sp_sync_be;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        we;
    logic        re;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    always #5 clk = ~clk;

    ram_sp_sync_be_if #(.ADDR_W(10), .DATA_W(32)) b0 ();
    ram_sp_sync_be_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
    ram_sp_sync_be_if #(.ADDR_W(10), .DATA_W(32)) b2 ();

    assign {b0.cs, b0.we, b0.re, b0.addr, b0.wdata, b0.be} = {cs, we, re, addr, wdata, be};
    assign {b1.cs, b1.we, b1.re, b1.addr, b1.wdata, b1.be} = {cs, we, re, addr, wdata, be};
    assign {b2.cs, b2.we, b2.re, b2.addr, b2.wdata, b2.be} = {cs, we, re, addr, wdata, be};

    ram_sp_sync_be #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(16),
        .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    ram_sp_sync_be #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(16),
        .RD_LAT(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    ram_sp_sync_be #(
        .ADDR_W(10), .DATA_W(32), .DEPTH(1000),
        .RD_LAT(3), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic [31:0] rd  [3];
    logic        rv  [3];
    logic        rdy [3];
    logic        er  [3];

    assign rd[0] = b0.rdata, rv[0] = b0.rvalid, rdy[0] = b0.ready, er[0] = b0.err;
    assign rd[1] = b1.rdata, rv[1] = b1.rvalid, rdy[1] = b1.ready, er[1] = b1.err;
    assign rd[2] = b2.rdata, rv[2] = b2.rvalid, rdy[2] = b2.ready, er[2] = b2.err;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int inst,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: got %h want %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] b);
        merge = o;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) merge[8*i +: 8] = d[8*i +: 8];
        end
    endfunction

    // Memory model: per-instance word arrays, a countdown for the sweep and
    // a small ring of result slots keyed by the edge they become visible on.
    int          dep [3] = '{16, 16, 1000};
    int          lat [3] = '{1, 2, 3};
    int          rdw [3] = '{0, 1, 0};
    logic [31:0] mm  [3][1024];
    int          clr [3];
    logic        sv  [3][4];
    logic [31:0] sd  [3][4];
    logic        ev  [3];
    logic        eerr[3];
    logic        erdy[3];
    logic [31:0] ehold[3];
    int          ecyc = 0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        int s;
        int t;
        logic [31:0] old;
        logic [31:0] nw;
        logic inr;
        s = ecyc % 4;
        for (int i = 0; i < 3; i++) begin
            eerr[i] = 1'b0;
            if (!rst_n) begin
                clr[i] = dep[i];
                for (int j = 0; j < 1024; j++) mm[i][j] = '0;
                for (int k = 0; k < 4; k++) sv[i][k] = 1'b0;
                ehold[i] = '0;
            end else begin
                if (cs && clr[i] == 0 && (we || re)) begin
                    inr = addr < dep[i];
                    old = inr ? mm[i][addr] : 32'h0;
                    nw  = we ? merge(old, wdata, be) : old;
                    if (we && inr) mm[i][addr] = nw;
                    if (re) begin
                        t = (ecyc + lat[i] - 1) % 4;
                        sv[i][t] = 1'b1;
                        sd[i][t] = !inr ? 32'h0 : (rdw[i] != 0 ? nw : old);
                    end
                    eerr[i] = !inr;
                end
                if (clr[i] > 0) clr[i]--;
            end
            ev[i] = sv[i][s];
            if (ev[i]) ehold[i] = sd[i][s];
            sv[i][s] = 1'b0;
            erdy[i] = (clr[i] == 0);
        end
        if (!rst_n) started = 1'b1;
        ecyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk("rvalid", i, 32'(rv[i]), 32'(ev[i]));
                chk("ready", i, 32'(rdy[i]), 32'(erdy[i]));
                chk("err", i, 32'(er[i]), 32'(eerr[i]));
                chk("rdata", i, rd[i], ehold[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input int a,
                      input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; we = w; re = r; addr = 10'(a); wdata = d; be = b;
        tick();
        cs = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic wait_ready(input int inst, input int limit, output int n);
        n = 0;
        while (!rdy[inst] && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; cs = 1'b0; we = 1'b0; re = 1'b0;
        addr = '0; wdata = '0; be = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_rdata", 0, rd[0], 32'h0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'h0);

        wait_ready(0, 100, n);
        chk("clear_len", 0, n, 16);
        wait_ready(2, 1200, n);
        chk("clear_len", 2, n + 16, 1000);
        for (int a = 0; a < 16; a++) op(1'b0, 1'b1, a, 32'h0, 4'h0);
        repeat (4) tick();

        op(1'b1, 1'b0, 5, 32'hDEADBEEF, 4'hF);
        op(1'b1, 1'b0, 5, 32'h11223344, 4'b0101);
        op(1'b0, 1'b1, 5, 32'h0, 4'h0);
        chk("be_lat1", 0, rd[0], 32'hDE22BE44);
        chk("lat2_early", 1, 32'(rv[1]), 32'h0);
        tick();
        chk("be_lat2", 1, rd[1], 32'hDE22BE44);
        chk("lat3_early", 2, 32'(rv[2]), 32'h0);
        tick();
        chk("be_lat3", 2, rd[2], 32'hDE22BE44);
        chk("lat3_valid", 2, 32'(rv[2]), 32'h1);
        tick();

        op(1'b1, 1'b0, 7, 32'hAAAAAAAA, 4'hF);
        op(1'b1, 1'b1, 7, 32'h55555555, 4'h3);
        chk("rdw_old", 0, rd[0], 32'hAAAAAAAA);
        tick();
        chk("rdw_new", 1, rd[1], 32'hAAAA5555);
        tick();
        chk("rdw_old", 2, rd[2], 32'hAAAAAAAA);
        op(1'b0, 1'b1, 7, 32'h0, 4'h0);
        chk("rdw_after", 0, rd[0], 32'hAAAA5555);
        tick();
        tick();
        chk("rdw_after", 2, rd[2], 32'hAAAA5555);

        for (int a = 0; a < 4; a++) op(1'b1, 1'b0, a, 32'h10000000 + 32'(a) * 32'h0101, 4'hF);
        for (int k = 0; k < 6; k++) begin
            cs = (k < 4); re = (k < 4); we = 1'b0; addr = 10'(k);
            tick();
            if (k >= 1 && k <= 4) begin
                chk("b2b_valid", 1, 32'(rv[1]), 32'h1);
                chk("b2b_data", 1, rd[1], 32'h10000000 + 32'(k - 1) * 32'h0101);
            end
        end
        chk("b2b_end", 1, 32'(rv[1]), 32'h0);
        cs = 1'b0; re = 1'b0;
        tick();

        op(1'b1, 1'b0, 1000, 32'hCAFEF00D, 4'hF);
        chk("oor_err_w", 2, 32'(er[2]), 32'h1);
        op(1'b0, 1'b1, 1000, 32'h0, 4'h0);
        chk("oor_err_r", 2, 32'(er[2]), 32'h1);
        tick();
        chk("oor_err_end", 2, 32'(er[2]), 32'h0);
        tick();
        chk("oor_rdata", 2, rd[2], 32'h0);
        chk("oor_rvalid", 2, 32'(rv[2]), 32'h1);
        op(1'b1, 1'b0, 999, 32'h99999999, 4'hF);
        op(1'b1, 1'b0, 15, 32'h15151515, 4'hC);
        op(1'b1, 1'b0, 16, 32'h16161616, 4'hF);
        foreach (dep[i]) op(1'b0, 1'b1, 999 - i * 984, 32'h0, 4'h0);
        op(1'b0, 1'b1, 0, 32'h0, 4'h0);
        op(1'b0, 1'b1, 16, 32'h0, 4'h0);
        repeat (4) tick();

        cs = 1'b0; we = 1'b1; re = 1'b1; addr = 10'd5; wdata = '1; be = 4'hF;
        repeat (3) tick();
        we = 1'b0; re = 1'b0;
        op(1'b0, 1'b1, 5, 32'h0, 4'h0);
        chk("cs0_keep", 0, rd[0], 32'hDE22BE44);
        repeat (3) tick();

        for (int k = 0; k < 60; k++) begin
            int a;
            a = $urandom_range(0, 24);
            cs = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1);
            re = $urandom_range(0, 1);
            addr = (a < 18) ? 10'(a) : 10'(995 + a - 18);
            wdata = $urandom;
            be = 4'($urandom);
            tick();
        end
        cs = 1'b0; we = 1'b0; re = 1'b0;
        repeat (4) tick();

        for (int a = 0; a < 3; a++) op(1'b0, 1'b1, a, 32'h0, 4'h0);
        cs = 1'b1; re = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; cs = 1'b0; re = 1'b0;
        chk("rst_drop", 2, 32'(rv[2]), 32'h0);
        chk("rst_drop", 0, 32'(rv[0]), 32'h0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_ready(0, 100, n);
        chk("reclear_len", 0, n, 16);
        wait_ready(2, 1200, n);
        chk("reclear_len", 2, n + 16, 1000);
        for (int a = 0; a < 16; a++) op(1'b0, 1'b1, a, 32'h0, 4'h0);
        op(1'b0, 1'b1, 999, 32'h0, 4'h0);
        op(1'b0, 1'b1, 500, 32'h0, 4'h0);
        repeat (3) tick();
        chk("reclear_999", 2, rd[2], 32'h0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
